trap_sequencer: RTL and testbench

- Consumes the Memory-stage fault outputs of the privileged pipeline registers, together with the remaining M-stage exception sources.
- Prioritises them per the RISC-V exception priority order and latches cause, epc and tval.
- Runs a multi-cycle FSM that writes the epc, cause and tval CSRs over a ready/valid CSR write port, pulses the status update, then redirects fetch to the trap vector.
- Sits between the privileged pipeline registers and the CSR file; holds the M stage stalled while a trap is being committed.

---
 rtl/trap_sequencer_pkg.sv | 40 ++++
 rtl/trap_sequencer_priority.sv | 53 +++++
 rtl/trap_sequencer.sv | 164 ++++++++++++++++
 tb/tb_trap_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared privileged definitions for the trap sequencer: FSM states, tval
// selection codes, exception cause codes and trap CSR addresses.
package trap_sequencer_pkg;

   // Trap commit sequence: three CSR writes, a status pulse, then the redirect.
   typedef enum logic [2:0] {
      StIdle,
      StEpc,
      StCause,
      StTval,
      StStatus,
      StRedirect
   } trap_state_e;

   // Source of the trap value written to xtval.
   typedef enum logic [1:0] {
      TvalPc,
      TvalInstr,
      TvalAdr,
      TvalZero
   } tval_sel_e;

   // Synchronous exception cause codes.
   localparam int unsigned CauseInstrAccessFault = 1;
   localparam int unsigned CauseIllegalInstr     = 2;
   localparam int unsigned CauseBreakpoint       = 3;
   localparam int unsigned CauseLoadMisaligned   = 4;
   localparam int unsigned CauseStoreMisaligned  = 6;
   localparam int unsigned CauseEcallU           = 8;  // ecall cause is this plus privilege
   localparam int unsigned CauseInstrPageFault   = 12;

   // Trap CSR addresses.
   localparam logic [11:0] CsrMepc   = 12'h341;
   localparam logic [11:0] CsrMcause = 12'h342;
   localparam logic [11:0] CsrMtval  = 12'h343;
   localparam logic [11:0] CsrSepc   = 12'h141;
   localparam logic [11:0] CsrScause = 12'h142;
   localparam logic [11:0] CsrStval  = 12'h143;

endpackage

// File: rtl/trap_sequencer_priority.sv
// Combinational exception priority encoder: picks the single highest-priority
// M-stage fault and reports its cause code and which value feeds xtval.
module trap_priority
   import trap_sequencer_pkg::*;
#(
   parameter int unsigned CAUSEW = 4
) (
   input  logic              breakpoint,
   input  logic              instr_page_fault,
   input  logic              instr_access_fault,
   input  logic              illegal_instr,
   input  logic              ecall,
   input  logic              store_misaligned,
   input  logic              load_misaligned,
   input  logic [1:0]        priv,
   output logic              any_fault,
   output logic [CAUSEW-1:0] cause,
   output tval_sel_e         tval_sel
);

   // Raw fault presence, independent of instruction validity.
   assign any_fault = breakpoint | instr_page_fault | instr_access_fault | illegal_instr |
                      ecall | store_misaligned | load_misaligned;

   // Priority chain, highest first; only the winning cause is reported.
   always_comb begin
      cause    = '0;
      tval_sel = TvalZero;
      if (breakpoint) begin
         cause    = CAUSEW'(CauseBreakpoint);
         tval_sel = TvalPc;
      end else if (instr_page_fault) begin
         cause    = CAUSEW'(CauseInstrPageFault);
         tval_sel = TvalPc;
      end else if (instr_access_fault) begin
         cause    = CAUSEW'(CauseInstrAccessFault);
         tval_sel = TvalPc;
      end else if (illegal_instr) begin
         cause    = CAUSEW'(CauseIllegalInstr);
         tval_sel = TvalInstr;
      end else if (ecall) begin
         cause    = CAUSEW'(CauseEcallU + int'(priv));
         tval_sel = TvalZero;
      end else if (store_misaligned) begin
         cause    = CAUSEW'(CauseStoreMisaligned);
         tval_sel = TvalAdr;
      end else if (load_misaligned) begin
         cause    = CAUSEW'(CauseLoadMisaligned);
         tval_sel = TvalAdr;
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// Trap sequencer: latches the highest-priority M-stage exception, writes
// xepc/xcause/xtval over a ready/valid CSR port, pulses the status update and
// redirects fetch to the trap vector, stalling M throughout.
// Optional S-mode delegation is enabled by defining TRAP_SEQ_SDELEG_EN.
module trap_sequencer
   import trap_sequencer_pkg::*;
#(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned CAUSEW = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            InstrValidM,
   input  logic            InstrPageFaultM,
   input  logic            InstrAccessFaultM,
   input  logic            HPTWInstrAccessFaultM,
   input  logic            IllegalIEUFPUInstrM,
   input  logic            BreakpointFaultM,
   input  logic            EcallFaultM,
   input  logic            LoadMisalignedFaultM,
   input  logic            StoreAmoMisalignedFaultM,
   input  logic [1:0]      PrivilegeModeW,
   input  logic [XLEN-1:0] PCM,
   input  logic [31:0]     InstrM,
   input  logic [XLEN-1:0] IEUAdrM,
   input  logic [15:0]     MEDELEG_REGW,
   input  logic [XLEN-1:0] MTVEC_REGW,
   input  logic [XLEN-1:0] STVEC_REGW,
   output logic            CSRTrapWrValid,
   input  logic            CSRTrapWrReady,
   output logic [11:0]     CSRTrapWrAdr,
   output logic [XLEN-1:0] CSRTrapWrData,
   output logic            TrapStatusUpdate,
   output logic            TrapToS,
   output logic            TrapStallM,
   output logic            TrapRedirect,
   output logic [XLEN-1:0] TrapVectorM
);

   trap_state_e       state_q, state_d;
   logic [CAUSEW-1:0] cause_q;
   logic [XLEN-1:0]   epc_q;
   logic [XLEN-1:0]   tval_q;
   logic              to_s_q;

   logic              any_fault;
   logic              trap_detect;
   logic [CAUSEW-1:0] det_cause;
   tval_sel_e         det_tval_sel;
   logic [XLEN-1:0]   det_tval;
   logic              det_to_s;
   logic [XLEN-1:0]   tvec;
   logic              busy;

   trap_priority #(
      .CAUSEW(CAUSEW)
   ) u_priority (
      .breakpoint        (BreakpointFaultM),
      .instr_page_fault  (InstrPageFaultM),
      .instr_access_fault(InstrAccessFaultM | HPTWInstrAccessFaultM),
      .illegal_instr     (IllegalIEUFPUInstrM),
      .ecall             (EcallFaultM),
      .store_misaligned  (StoreAmoMisalignedFaultM),
      .load_misaligned   (LoadMisalignedFaultM),
      .priv              (PrivilegeModeW),
      .any_fault         (any_fault),
      .cause             (det_cause),
      .tval_sel          (det_tval_sel)
   );

   assign trap_detect = InstrValidM & any_fault;
   assign busy        = (state_q != StIdle);

   // Select the trap value for the winning exception.
   always_comb begin
      det_tval = '0;
      unique case (det_tval_sel)
         TvalPc:    det_tval = PCM;
         TvalInstr: det_tval = {{(XLEN-32){1'b0}}, InstrM};
         TvalAdr:   det_tval = IEUAdrM;
         default:   det_tval = '0;
      endcase
   end

`ifdef TRAP_SEQ_SDELEG_EN
   // Delegate to S when not already in M and the cause is delegated.
   assign det_to_s = (PrivilegeModeW != 2'd3) & MEDELEG_REGW[det_cause];
   assign tvec     = to_s_q ? STVEC_REGW : MTVEC_REGW;
`else
   // Every trap targets M; delegation inputs are deliberately ignored.
   logic unused_deleg;
   assign unused_deleg = ^{MEDELEG_REGW, STVEC_REGW};
   assign det_to_s     = 1'b0;
   assign tvec         = MTVEC_REGW;
`endif

   // State register and trap context, captured only when a trap is accepted.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         cause_q <= '0;
         epc_q   <= '0;
         tval_q  <= '0;
         to_s_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && trap_detect) begin
            cause_q <= det_cause;
            epc_q   <= PCM;
            tval_q  <= det_tval;
            to_s_q  <= det_to_s;
         end
      end
   end

   // Next-state and sequence outputs; CSR writes hold until accepted.
   always_comb begin
      state_d          = state_q;
      CSRTrapWrValid   = 1'b0;
      CSRTrapWrAdr     = '0;
      CSRTrapWrData    = '0;
      TrapStatusUpdate = 1'b0;
      TrapRedirect     = 1'b0;
      TrapVectorM      = '0;
      unique case (state_q)
         StIdle: begin
            if (trap_detect) state_d = StEpc;
         end
         StEpc: begin
            CSRTrapWrValid = 1'b1;
            CSRTrapWrAdr   = to_s_q ? CsrSepc : CsrMepc;
            CSRTrapWrData  = epc_q;
            if (CSRTrapWrReady) state_d = StCause;
         end
         StCause: begin
            CSRTrapWrValid = 1'b1;
            CSRTrapWrAdr   = to_s_q ? CsrScause : CsrMcause;
            CSRTrapWrData  = XLEN'(cause_q);  // MSB clear: exception, not interrupt
            if (CSRTrapWrReady) state_d = StTval;
         end
         StTval: begin
            CSRTrapWrValid = 1'b1;
            CSRTrapWrAdr   = to_s_q ? CsrStval : CsrMtval;
            CSRTrapWrData  = tval_q;
            if (CSRTrapWrReady) state_d = StStatus;
         end
         StStatus: begin
            TrapStatusUpdate = 1'b1;
            state_d          = StRedirect;
         end
         StRedirect: begin
            TrapRedirect = 1'b1;
            TrapVectorM  = {tvec[XLEN-1:2], 2'b00};  // exceptions always use the base
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Stall as soon as a trap is seen and until the redirect has been issued.
   assign TrapStallM = busy ? 1'b1 : trap_detect;
   assign TrapToS    = busy & to_s_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios followed by
// randomized traffic, checked each cycle against a queue-of-expected-beats model.
`timescale 1ns/1ps
module tb_trap_sequencer;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned CAUSEW = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            InstrValidM, InstrPageFaultM, InstrAccessFaultM, HPTWInstrAccessFaultM;
   logic            IllegalIEUFPUInstrM, BreakpointFaultM, EcallFaultM;
   logic            LoadMisalignedFaultM, StoreAmoMisalignedFaultM;
   logic [1:0]      PrivilegeModeW;
   logic [XLEN-1:0] PCM, IEUAdrM, MTVEC_REGW, STVEC_REGW;
   logic [31:0]     InstrM;
   logic [15:0]     MEDELEG_REGW;
   logic            CSRTrapWrValid, CSRTrapWrReady;
   logic [11:0]     CSRTrapWrAdr;
   logic [XLEN-1:0] CSRTrapWrData, TrapVectorM;
   logic            TrapStatusUpdate, TrapToS, TrapStallM, TrapRedirect;

   always #5 clk = ~clk;

   trap_sequencer #(.XLEN(XLEN), .CAUSEW(CAUSEW)) dut (
      .clk(clk), .reset(reset), .InstrValidM(InstrValidM),
      .InstrPageFaultM(InstrPageFaultM), .InstrAccessFaultM(InstrAccessFaultM),
      .HPTWInstrAccessFaultM(HPTWInstrAccessFaultM), .IllegalIEUFPUInstrM(IllegalIEUFPUInstrM),
      .BreakpointFaultM(BreakpointFaultM), .EcallFaultM(EcallFaultM),
      .LoadMisalignedFaultM(LoadMisalignedFaultM),
      .StoreAmoMisalignedFaultM(StoreAmoMisalignedFaultM), .PrivilegeModeW(PrivilegeModeW),
      .PCM(PCM), .InstrM(InstrM), .IEUAdrM(IEUAdrM), .MEDELEG_REGW(MEDELEG_REGW),
      .MTVEC_REGW(MTVEC_REGW), .STVEC_REGW(STVEC_REGW), .CSRTrapWrValid(CSRTrapWrValid),
      .CSRTrapWrReady(CSRTrapWrReady), .CSRTrapWrAdr(CSRTrapWrAdr),
      .CSRTrapWrData(CSRTrapWrData), .TrapStatusUpdate(TrapStatusUpdate), .TrapToS(TrapToS),
      .TrapStallM(TrapStallM), .TrapRedirect(TrapRedirect), .TrapVectorM(TrapVectorM)
   );

   // Reference model: pending beats of the trap being committed.
   typedef enum int {BeatWrite, BeatStatus, BeatRedirect} beat_kind_e;
   typedef struct {
      beat_kind_e  kind;
      logic [11:0] adr;
      logic [63:0] data;
   } beat_t;

   beat_t exp_q[$];
   bit    exp_to_s = 1'b0;
   int    n_vec = 0;
   int    n_err = 0;
   int    cycle = 0;

   logic [63:0] obs_epc, obs_cause, obs_tval, obs_vec;
   logic [11:0] obs_cause_adr;
   int          redirect_cycle = -1;
   int          det_cycle;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   function automatic bit model_detect();
      return InstrValidM && (InstrPageFaultM || InstrAccessFaultM || HPTWInstrAccessFaultM ||
             IllegalIEUFPUInstrM || BreakpointFaultM || EcallFaultM ||
             LoadMisalignedFaultM || StoreAmoMisalignedFaultM);
   endfunction

   // Exception priority and trap value, straight from the architectural rules.
   task automatic classify(output int cause, output logic [63:0] tval);
      if (BreakpointFaultM)                                 begin cause = 3;  tval = PCM; end
      else if (InstrPageFaultM)                             begin cause = 12; tval = PCM; end
      else if (InstrAccessFaultM || HPTWInstrAccessFaultM)  begin cause = 1;  tval = PCM; end
      else if (IllegalIEUFPUInstrM)                         begin cause = 2;  tval = 64'(InstrM); end
      else if (EcallFaultM)             begin cause = 8 + int'(PrivilegeModeW); tval = '0; end
      else if (StoreAmoMisalignedFaultM)                    begin cause = 6;  tval = IEUAdrM; end
      else                                                  begin cause = 4;  tval = IEUAdrM; end
   endtask

   task automatic build_trap();
      int          cause;
      logic [63:0] tval;
      classify(cause, tval);
`ifdef TRAP_SEQ_SDELEG_EN
      exp_to_s = (PrivilegeModeW != 2'd3) && MEDELEG_REGW[cause];
`else
      exp_to_s = 1'b0;
`endif
      exp_q.push_back('{BeatWrite, exp_to_s ? 12'h141 : 12'h341, PCM});
      exp_q.push_back('{BeatWrite, exp_to_s ? 12'h142 : 12'h342, 64'(cause)});
      exp_q.push_back('{BeatWrite, exp_to_s ? 12'h143 : 12'h343, tval});
      exp_q.push_back('{BeatStatus, 12'h0, 64'h0});
      exp_q.push_back('{BeatRedirect, 12'h0, 64'h0});
   endtask

   // Compare DUT outputs against the head of the expected-beat queue.
   task automatic check_outputs();
      bit busy, w, st, rd;
      busy = exp_q.size() != 0;
      w = 1'b0; st = 1'b0; rd = 1'b0;
      if (busy) begin
         w  = exp_q[0].kind == BeatWrite;
         st = exp_q[0].kind == BeatStatus;
         rd = exp_q[0].kind == BeatRedirect;
      end
      check_val("stall", TrapStallM, busy | model_detect());
      check_val("wr_valid", CSRTrapWrValid, w);
      if (w) begin
         check_val("wr_adr", CSRTrapWrAdr, exp_q[0].adr);
         check_val("wr_data", CSRTrapWrData, exp_q[0].data);
      end
      check_val("status", TrapStatusUpdate, st);
      check_val("redirect", TrapRedirect, rd);
      check_val("vector", TrapVectorM,
                rd ? ((exp_to_s ? STVEC_REGW : MTVEC_REGW) & ~64'h3) : 64'h0);
      check_val("to_s", TrapToS, busy & exp_to_s);
      if (CSRTrapWrValid && CSRTrapWrReady) begin
         case (CSRTrapWrAdr)
            12'h341, 12'h141: obs_epc = CSRTrapWrData;
            12'h342, 12'h142: begin obs_cause = CSRTrapWrData; obs_cause_adr = CSRTrapWrAdr; end
            12'h343, 12'h143: obs_tval = CSRTrapWrData;
            default: ;
         endcase
      end
      if (TrapRedirect) begin
         obs_vec        = TrapVectorM;
         redirect_cycle = cycle;
      end
   endtask

   task automatic model_step();
      if (!reset) exp_q.delete();
      else if (exp_q.size() == 0) begin
         if (model_detect()) build_trap();
      end else if (exp_q[0].kind != BeatWrite || CSRTrapWrReady) begin
         void'(exp_q.pop_front());
      end
   endtask

   // One clock: check at the falling edge, advance the model at the rising edge.
   task automatic run_cycle();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_step();
      cycle++;
      #1;
   endtask

   task automatic clear_faults();
      InstrValidM = 1'b0; InstrPageFaultM = 1'b0; InstrAccessFaultM = 1'b0;
      HPTWInstrAccessFaultM = 1'b0; IllegalIEUFPUInstrM = 1'b0; BreakpointFaultM = 1'b0;
      EcallFaultM = 1'b0; LoadMisalignedFaultM = 1'b0; StoreAmoMisalignedFaultM = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (exp_q.size() != 0 || TrapStallM); i++) run_cycle();
      check_val("drain_idle", TrapStallM, 1'b0);
   endtask

   initial begin
      reset = 1'b0; CSRTrapWrReady = 1'b1; PrivilegeModeW = 2'd3;
      PCM = '0; InstrM = '0; IEUAdrM = '0; MEDELEG_REGW = '0;
      MTVEC_REGW = 64'h8000_0101; STVEC_REGW = 64'h4000_0203;
      clear_faults();
      repeat (3) run_cycle();
      reset = 1'b1;
      run_cycle();

      // Illegal instruction, M target, Ready always high.
      PCM = 64'h8000_0010; InstrM = 32'h0000_FFFF;
      InstrValidM = 1'b1; IllegalIEUFPUInstrM = 1'b1;
      det_cycle = cycle;
      run_cycle();
      clear_faults();
      drain();
      check_val("t1_epc", obs_epc, 64'h8000_0010);
      check_val("t1_cause", obs_cause, 64'd2);
      check_val("t1_tval", obs_tval, 64'hFFFF);
      check_val("t1_vector", obs_vec, 64'h8000_0100);
      check_val("t1_latency", 64'(redirect_cycle - det_cycle), 64'd5);

      // Page fault beats illegal instruction.
      PCM = 64'h1234_5678_9ABC_DEF0; InstrM = 32'hDEAD_BEEF;
      InstrValidM = 1'b1; InstrPageFaultM = 1'b1; IllegalIEUFPUInstrM = 1'b1;
      run_cycle();
      clear_faults();
      drain();
      check_val("t2_cause", obs_cause, 64'd12);
      check_val("t2_tval", obs_tval, 64'h1234_5678_9ABC_DEF0);

      // Page-walk access fault reported as instruction access fault.
      PCM = 64'h0000_0000_0000_2468; InstrValidM = 1'b1; HPTWInstrAccessFaultM = 1'b1;
      run_cycle();
      clear_faults();
      drain();
      check_val("t3_cause", obs_cause, 64'd1);
      check_val("t3_tval", obs_tval, 64'h2468);

      // U-mode ecall with cause 8 delegated.
      PrivilegeModeW = 2'd0; MEDELEG_REGW = 16'h0100;
      InstrValidM = 1'b1; EcallFaultM = 1'b1;
      run_cycle();
      clear_faults();
      drain();
      check_val("t4_cause", obs_cause, 64'd8);
      check_val("t4_tval", obs_tval, 64'd0);
`ifdef TRAP_SEQ_SDELEG_EN
      check_val("t4_cause_adr", obs_cause_adr, 12'h142);
      check_val("t4_vector", obs_vec, 64'h4000_0200);
`else
      check_val("t4_cause_adr", obs_cause_adr, 12'h342);
      check_val("t4_vector", obs_vec, 64'h8000_0100);
`endif
      PrivilegeModeW = 2'd3; MEDELEG_REGW = '0;

      // Ready low for three cycles during the cause write.
      PCM = 64'h8000_0040; InstrM = 32'h0000_0013;
      InstrValidM = 1'b1; IllegalIEUFPUInstrM = 1'b1;
      det_cycle = cycle;
      run_cycle();
      clear_faults();
      run_cycle();
      CSRTrapWrReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run_cycle();
         check_val("t5_hold_adr", CSRTrapWrAdr, 12'h342);
      end
      CSRTrapWrReady = 1'b1;
      drain();
      check_val("t5_latency", 64'(redirect_cycle - det_cycle), 64'd8);

      // Reset during the tval write, then a fresh trap two cycles later.
      PCM = 64'h8000_0080; InstrValidM = 1'b1; BreakpointFaultM = 1'b1;
      run_cycle();
      clear_faults();
      run_cycle();
      run_cycle();
      reset = 1'b0;
      run_cycle();
      reset = 1'b1;
      check_val("t6_reset_valid", CSRTrapWrValid, 1'b0);
      check_val("t6_reset_stall", TrapStallM, 1'b0);
      run_cycle();
      PCM = 64'h8000_00C0; InstrValidM = 1'b1; LoadMisalignedFaultM = 1'b1;
      IEUAdrM = 64'h0000_0000_1000_0003;
      det_cycle = cycle;
      run_cycle();
      clear_faults();
      drain();
      check_val("t6_epc", obs_epc, 64'h8000_00C0);
      check_val("t6_cause", obs_cause, 64'd4);
      check_val("t6_tval", obs_tval, 64'h1000_0003);
      check_val("t6_latency", 64'(redirect_cycle - det_cycle), 64'd5);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         reset                    = $urandom_range(0, 79) != 0;
         CSRTrapWrReady           = $urandom_range(0, 3) != 0;
         InstrValidM              = $urandom_range(0, 3) != 0;
         InstrPageFaultM          = $urandom_range(0, 11) == 0;
         InstrAccessFaultM        = $urandom_range(0, 11) == 0;
         HPTWInstrAccessFaultM    = $urandom_range(0, 11) == 0;
         IllegalIEUFPUInstrM      = $urandom_range(0, 11) == 0;
         BreakpointFaultM         = $urandom_range(0, 11) == 0;
         EcallFaultM              = $urandom_range(0, 11) == 0;
         LoadMisalignedFaultM     = $urandom_range(0, 11) == 0;
         StoreAmoMisalignedFaultM = $urandom_range(0, 11) == 0;
         case ($urandom_range(0, 2))
            0:       PrivilegeModeW = 2'd0;
            1:       PrivilegeModeW = 2'd1;
            default: PrivilegeModeW = 2'd3;
         endcase
         PCM          = {$urandom, $urandom};
         IEUAdrM      = {$urandom, $urandom};
         InstrM       = $urandom;
         MEDELEG_REGW = 16'($urandom);
         MTVEC_REGW   = {$urandom, $urandom};
         STVEC_REGW   = {$urandom, $urandom};
         run_cycle();
      end
      reset = 1'b1;
      CSRTrapWrReady = 1'b1;
      clear_faults();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
